vga_timing_gen: RTL and testbench

- Pixel-clock timing master for the VGA output path.
- Generates the pixel tick, horizontal and vertical counters, and the x/y coordinate for the colour logic (border/background generator, sprite overlays).
- Takes the resulting 8-bit RGB back and registers it with blanking applied.
- Drives hsync, vsync and blank to the DAC/pins, aligned with the pixel data.

---
 rtl/vga_timing_gen.sv | 136 +++++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA pixel-clock timing master.
// Divides the system clock down to a pixel tick, runs the horizontal/vertical
// counters, presents x/y to the colour logic and registers the returned RGB
// together with hsync, vsync and blank so that all pin outputs stay aligned.
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   pix_r/g/b [7:0]     colour for the current x/y (combinational from colour logic)
//   x, y [11:0]         current horizontal / vertical counter
//   pix_tick            one-clk strobe, counters and pins advance on this cycle's edge
//   frame_start         one-clk strobe, counters just wrapped to (0,0)
//   vga_r/g/b [7:0]     registered colour, zero during blanking
//   vga_hs, vga_vs      registered sync outputs
//   vga_blank_n         1 = active video on vga_r/g/b
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        pix_tick,
    output logic        frame_start,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
    localparam logic [11:0]     HLast    = 12'(H_TOTAL - 1);
    localparam logic [11:0]     VLast    = 12'(V_TOTAL - 1);
    localparam logic [11:0]     HActive  = 12'(H_ACTIVE);
    localparam logic [11:0]     VActive  = 12'(V_ACTIVE);
    localparam logic [11:0]     HsStart  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0]     HsEnd    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0]     VsStart  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0]     VsEnd    = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [DivW-1:0] div_q, div_d;
    logic            pix_tick_q;
    logic            frame_start_q;
    logic [11:0]     h_cnt_q, h_cnt_d;
    logic [11:0]     v_cnt_q, v_cnt_d;
    logic [7:0]      vga_r_q, vga_g_q, vga_b_q;
    logic            vga_hs_q, vga_vs_q, vga_blank_n_q;

    logic div_last, h_last, v_last;
    logic active, hs_on, vs_on;

    always_comb begin
        div_last = (div_q == DivLast);
        div_d    = div_last ? '0 : div_q + DivW'(1);

        h_last = (h_cnt_q == HLast);
        v_last = (v_cnt_q == VLast);

        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_tick_q) begin
            if (h_last) begin
                // v only moves at the line wrap, so vsync never changes mid-line
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + 12'd1;
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
            end
        end

        // Decode on the counters before they advance: the pins lag x/y by one pixel
        active = (h_cnt_q < HActive) && (v_cnt_q < VActive);
        hs_on  = (h_cnt_q >= HsStart) && (h_cnt_q < HsEnd);
        vs_on  = (v_cnt_q >= VsStart) && (v_cnt_q < VsEnd);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q         <= '0;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            vga_r_q       <= '0;
            vga_g_q       <= '0;
            vga_b_q       <= '0;
            vga_blank_n_q <= 1'b0;
            vga_hs_q      <= ~HS_POL;
            vga_vs_q      <= ~VS_POL;
        end else begin
            div_q         <= div_d;
            pix_tick_q    <= div_last;
            frame_start_q <= pix_tick_q && h_last && v_last;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            if (pix_tick_q) begin
                vga_r_q       <= active ? pix_r : 8'd0;
                vga_g_q       <= active ? pix_g : 8'd0;
                vga_b_q       <= active ? pix_b : 8'd0;
                vga_blank_n_q <= active;
                vga_hs_q      <= hs_on ? HS_POL : ~HS_POL;
                vga_vs_q      <= vs_on ? VS_POL : ~VS_POL;
            end
        end
    end

    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign pix_tick    = pix_tick_q;
    assign frame_start = frame_start_q;
    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_blank_n = vga_blank_n_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance (CLK_DIV=2) and a tiny
// CLK_DIV=1 instance, each with random colour stimulus, a pixel-index model,
// an expectation queue and a monitor that pops on every pix_tick.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit done [2];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned HA  = (g == 0) ? 640 : 8;
        localparam int unsigned HF  = (g == 0) ? 16  : 2;
        localparam int unsigned HSW = (g == 0) ? 96  : 2;
        localparam int unsigned HB  = (g == 0) ? 48  : 2;
        localparam int unsigned VA  = (g == 0) ? 480 : 4;
        localparam int unsigned VF  = (g == 0) ? 10  : 1;
        localparam int unsigned VSW = (g == 0) ? 2   : 1;
        localparam int unsigned VB  = (g == 0) ? 33  : 1;
        localparam int unsigned D   = (g == 0) ? 2   : 1;
        localparam int unsigned HT  = HA + HF + HSW + HB;
        localparam int unsigned VT  = VA + VF + VSW + VB;
        // Mid-frame reset point, as a pixel index: (300,2) and, after two frames, (5,3)
        localparam longint TRIG = (g == 0) ? longint'(2 * HT + 300)
                                           : longint'(2 * HT * VT + 3 * HT + 5);
        localparam int RUN0 = (g == 0) ? 5000 : 400;
        localparam int RUN1 = (g == 0) ? 2000 : 300;

        typedef struct packed {
            logic [11:0] nx;
            logic [11:0] ny;
            logic [7:0]  r;
            logic [7:0]  gr;
            logic [7:0]  b;
            logic        bn;
            logic        hs;
            logic        vs;
            logic        fs;
        } rec_t;

        logic        rst_n;
        logic [7:0]  pr, pg, pb;
        logic [11:0] x, y;
        logic        tick, fs;
        logic [7:0]  vr, vg, vb;
        logic        hs, vs, bn;

        rec_t exp_q[$];
        int   pushed = 0;
        int   popped = 0;
        int   fs_exp = 0;
        int   fs_seen = 0;

        vga_timing_gen #(
            .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
            .CLK_DIV(D), .HS_POL(1'b0), .VS_POL(1'b0)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .pix_r      (pr),
            .pix_g      (pg),
            .pix_b      (pb),
            .x          (x),
            .y          (y),
            .pix_tick   (tick),
            .frame_start(fs),
            .vga_r      (vr),
            .vga_g      (vg),
            .vga_b      (vb),
            .vga_hs     (hs),
            .vga_vs     (vs),
            .vga_blank_n(bn)
        );

        // Edge c (1-based after release) moves the pixel when c-1 is a non-zero multiple of D
        function automatic bit tick_edge(input int c);
            return (c - 1 >= int'(D)) && ((c - 1) % int'(D) == 0);
        endfunction

        // Pins after the edge that consumes pixel index n
        function automatic rec_t model(input longint n, input logic [7:0] r, gi, b);
            rec_t   m;
            longint h  = n % HT;
            longint v  = (n / HT) % VT;
            longint nh = (n + 1) % HT;
            longint nv = ((n + 1) / HT) % VT;
            bit act = (h < HA) && (v < VA);
            m.nx = 12'(nh);
            m.ny = 12'(nv);
            m.r  = act ? r : 8'd0;
            m.gr = act ? gi : 8'd0;
            m.b  = act ? b : 8'd0;
            m.bn = act;
            m.hs = !((h >= HA + HF) && (h < HA + HF + HSW));
            m.vs = !((v >= VA + VF) && (v < VA + VF + VSW));
            m.fs = (nh == 0) && (nv == 0);
            return m;
        endfunction

        function automatic rec_t reset_rec();
            rec_t m;
            m = '0;
            m.hs = 1'b1;
            m.vs = 1'b1;
            return m;
        endfunction

        initial begin : stim
            int     c;
            longint cur_n;
            rec_t   m;
            string  p;
            p = $sformatf("i%0d", g);
            rst_n = 1'b0;
            pr = 8'hff; pg = 8'hff; pb = 8'hff;
            repeat (5) @(negedge clk);
            chk({p, " reset x"}, x, 0);
            chk({p, " reset y"}, y, 0);
            chk({p, " reset pix_tick"}, tick, 0);
            chk({p, " reset frame_start"}, fs, 0);
            chk({p, " reset vga_r"}, vr, 0);
            chk({p, " reset vga_g"}, vg, 0);
            chk({p, " reset vga_b"}, vb, 0);
            chk({p, " reset blank_n"}, bn, 0);
            chk({p, " reset hs"}, hs, 1);
            chk({p, " reset vs"}, vs, 1);

            for (int phase = 0; phase < 2; phase++) begin
                rst_n = 1'b1;
                c     = 0;
                cur_n = 0;
                for (int i = 0; i < ((phase == 0) ? RUN0 : RUN1); i++) begin
                    pr = 8'($urandom);
                    pg = 8'($urandom);
                    pb = ($urandom_range(0, 1) == 0) ? 8'hA5 : 8'($urandom);
                    c++;
                    if (tick_edge(c)) begin
                        m = model(cur_n, pr, pg, pb);
                        exp_q.push_back(m);
                        pushed++;
                        if (m.fs) fs_exp++;
                        cur_n++;
                    end
                    @(negedge clk);
                    if (i < 4) chk({p, " early pix_tick"}, tick,
                                   longint'((c >= int'(D)) && (c % int'(D) == 0)));
                    if (phase == 0 && cur_n == TRIG) break;
                end
                if (phase == 0) chk({p, " reached reset point"}, cur_n, TRIG);
                // One-clock reset, landing wherever the frame happens to be
                rst_n = 1'b0;
                c++;
                if (tick_edge(c)) begin
                    exp_q.push_back(reset_rec());
                    pushed++;
                end
                @(posedge clk);
                #1;
                chk({p, " rst x"}, x, 0);
                chk({p, " rst y"}, y, 0);
                chk({p, " rst hs"}, hs, 1);
                chk({p, " rst vs"}, vs, 1);
                chk({p, " rst blank_n"}, bn, 0);
                chk({p, " rst pix_tick"}, tick, 0);
                chk({p, " rst frame_start"}, fs, 0);
                @(negedge clk);
            end
            repeat (3) @(negedge clk);
            chk({p, " ticks popped"}, popped, pushed);
            chk({p, " queue left"}, exp_q.size(), 0);
            chk({p, " frame_start count"}, fs_seen, fs_exp);
            done[g] = 1'b1;
        end

        initial begin : mon
            rec_t  m;
            string p;
            p = $sformatf("i%0d", g);
            forever begin
                @(negedge clk);
                if (fs) fs_seen++;
                if (tick) begin
                    @(posedge clk);
                    #1;
                    if (exp_q.size() == 0) begin
                        chk({p, " unexpected pix_tick"}, 1, 0);
                    end else begin
                        m = exp_q.pop_front();
                        popped++;
                        chk({p, " x"}, x, m.nx);
                        chk({p, " y"}, y, m.ny);
                        chk({p, " vga_r"}, vr, m.r);
                        chk({p, " vga_g"}, vg, m.gr);
                        chk({p, " vga_b"}, vb, m.b);
                        chk({p, " blank_n"}, bn, m.bn);
                        chk({p, " hs"}, hs, m.hs);
                        chk({p, " vs"}, vs, m.vs);
                        chk({p, " frame_start"}, fs, m.fs);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 60000 && !(done[0] && done[1]); i++) @(posedge clk);
        if (!(done[0] && done[1])) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: done=%0d%0d, expected 11", done[0], done[1]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
